// File: rtl/serialmul_sched.sv
// serialmul_sched
//
// Control block for a bit-serial 8x8 multiplier. Two requesters compete
// for a single datapath through a round-robin arbiter. An accepted operand
// pair is latched onto dp_a/dp_b. A three-deep strobe chain then frames the
// P/S converter, the multiplier array and the S/P converter. The product on
// dp_q is captured RES_LAT cycles after the first strobe and is offered on
// the result port until it is taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester keeps valid and its data stable until it sees
// ready. in0_ready/in1_ready depend combinationally on the valids, but only
// in IDLE. res_valid is held with res_q/res_id stable until res_ready.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in0_* / in1_*            operand handshakes (valid, ready, a, b)
//   dp_a, dp_b               operands driven to the datapath
//   dp_sync0/1/2             one-cycle frame strobes, one cycle apart
//   dp_q                     product returned by the datapath
//   res_valid/res_ready      result handshake
//   res_q, res_id            captured product and the requester it belongs to
//   busy                     high whenever the FSM is not in IDLE
//   dbg_state                current FSM state (IDLE=0 ISSUE=1 RUN=2 DONE=3)
module serialmul_sched #(
    parameter int FRAME   = 16,
    parameter int RES_LAT = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic [7:0]  in0_a,
    input  logic [7:0]  in0_b,
    input  logic        in1_valid,
    output logic        in1_ready,
    input  logic [7:0]  in1_a,
    input  logic [7:0]  in1_b,
    output logic [7:0]  dp_a,
    output logic [7:0]  dp_b,
    output logic        dp_sync0,
    output logic        dp_sync1,
    output logic        dp_sync2,
    input  logic [15:0] dp_q,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_q,
    output logic        res_id,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Wide enough that the count cannot wrap during one operation.
    localparam int CW = $clog2(FRAME + RES_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;        // requester that wins a tie
    logic [CW-1:0]   cnt_q, cnt_d;        // cycles since ISSUE (0 in ISSUE)
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic            id_q, id_d;
    logic [15:0]     res_data_q, res_data_d;
    logic            sync0_q, sync0_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;

    logic            grant0, grant1;

    // Round-robin grant: a sole requester always wins; on a tie the pointer
    // decides. Nothing is granted outside IDLE.
    always_comb begin
        grant0 = (state_q == IDLE) && in0_valid && (!in1_valid || !ptr_q);
        grant1 = (state_q == IDLE) && in1_valid && (!in0_valid ||  ptr_q);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        res_data_d = res_data_q;
        sync0_d    = 1'b0;
        // The later strobes are delayed copies of sync0.
        sync1_d    = sync0_q;
        sync2_d    = sync1_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant1 ? in1_a : in0_a;
                    b_d     = grant1 ? in1_b : in0_b;
                    id_d    = grant1;
                    ptr_d   = !grant1;
                    cnt_d   = '0;
                    sync0_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = RUN;
            end
            RUN: begin
                // cnt_q == RES_LAT in the cycle whose closing edge is the
                // first one at which the S/P converter holds the product.
                if (cnt_q == CW'(RES_LAT)) begin
                    res_data_d = dp_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            res_data_q <= '0;
            sync0_q    <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            res_data_q <= res_data_d;
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign in0_ready = grant0;
    assign in1_ready = grant1;
    assign dp_a      = a_q;
    assign dp_b      = b_q;
    assign dp_sync0  = sync0_q;
    assign dp_sync1  = sync1_q;
    assign dp_sync2  = sync2_q;
    assign res_valid = (state_q == DONE);
    assign res_q     = res_data_q;
    assign res_id    = id_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serialmul_sched.sv
// Bench for serialmul_sched. The datapath model below presents dp_a*dp_b on
// dp_q only in the single cycle RES_LAT cycles after the dp_sync0 pulse,
// and 16'hDEAD otherwise, so a capture at the wrong cycle is visible.
// All stimulus is applied, and all outputs are sampled, around the falling
// clock edge.
module tb_serialmul_sched;

    localparam int RES_LAT = 18;
    localparam int DONE_K  = RES_LAT + 2;   // cycles from accept to first res_valid

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid;
    logic        in0_ready, in1_ready;
    logic [7:0]  in0_a, in0_b, in1_a, in1_b;
    logic [7:0]  dp_a, dp_b;
    logic        dp_sync0, dp_sync1, dp_sync2;
    logic [15:0] dp_q;
    logic        res_valid, res_ready;
    logic [15:0] res_q;
    logic        res_id;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serialmul_sched #(.FRAME(16), .RES_LAT(RES_LAT)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_sync0(dp_sync0), .dp_sync1(dp_sync1), .dp_sync2(dp_sync2),
        .dp_q(dp_q),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_id(res_id), .busy(busy), .dbg_state(dbg_state)
    );

    // Datapath model: mc counts cycles since the dp_sync0 pulse.
    int mc;
    always @(posedge clk) begin
        if (rst)                     mc <= 0;
        else if (dp_sync0)           mc <= 1;
        else if (mc != 0 && mc < 200) mc <= mc + 1;
    end
    assign dp_q = (mc == RES_LAT) ? ({8'h00, dp_a} * {8'h00, dp_b}) : 16'hDEAD;

    // One full operation from the requester sel, starting in an IDLE cycle
    // at a falling edge. hold = number of extra DONE cycles with res_ready low.
    task automatic do_op(input logic sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_q, input logic exp_id,
                         input int hold, input string name);
        logic [6:0]  got, exp;
        logic [19:0] hgot, hexp;
        if (sel) begin in1_a = a; in1_b = b; in1_valid = 1'b1; end
        else     begin in0_a = a; in0_b = b; in0_valid = 1'b1; end
        #1;
        total++;
        if ({in0_ready, in1_ready} !== (sel ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL %s grant: ready0/1 got %b want %b", name,
                     {in0_ready, in1_ready}, (sel ? 2'b01 : 2'b10));
        end
        @(negedge clk);
        if (sel) in1_valid = 1'b0; else in0_valid = 1'b0;
        res_ready = (hold == 0);
        for (int k = 1; k <= DONE_K; k++) begin
            #1;
            got = {dp_sync0, dp_sync1, dp_sync2, res_valid, busy, in0_ready, in1_ready};
            exp = {k == 1, k == 2, k == 3, k == DONE_K, 1'b1, 2'b00};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s ctl T+%0d: s0 s1 s2 rv busy r0 r1 got %b want %b",
                         name, k, got, exp);
            end
            total++;
            if ({dp_a, dp_b} !== {a, b}) begin
                bad++;
                $display("FAIL %s operands T+%0d: got %h want %h", name, k,
                         {dp_a, dp_b}, {a, b});
            end
            if (k < DONE_K) @(negedge clk);
        end
        total++;
        if ({res_q, res_id} !== {exp_q, exp_id}) begin
            bad++;
            $display("FAIL %s result: q/id got %h/%0d want %h/%0d", name,
                     res_q, res_id, exp_q, exp_id);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            hgot = {res_valid, busy, in0_ready, in1_ready, res_q};
            hexp = {1'b1, 1'b1, 2'b00, exp_q};
            total++;
            if (hgot !== hexp || res_id !== exp_id) begin
                bad++;
                $display("FAIL %s hold %0d: rv busy r0 r1 q got %h/%0d want %h/%0d",
                         name, h, hgot, res_id, hexp, exp_id);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({busy, res_valid, dbg_state} !== 4'b0000) begin
            bad++;
            $display("FAIL %s release: busy rv state got %b want 0000", name,
                     {busy, res_valid, dbg_state});
        end
        res_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++;
        if ({dp_a, dp_b, dp_sync0, dp_sync1, dp_sync2, res_valid, res_q, res_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got a=%h b=%h s=%b rv=%b q=%h id=%b busy=%b want all 0",
                     dp_a, dp_b, {dp_sync0, dp_sync1, dp_sync2}, res_valid, res_q, res_id, busy);
        end
        // A lone requester wins; dropped again before the edge so nothing is accepted.
        in1_valid = 1'b1;
        #1;
        total++;
        if ({in0_ready, in1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_lone_in1: ready0/1 got %b want 01", {in0_ready, in1_ready});
        end
        in1_valid = 1'b0;
        #1;
        total++;
        if ({in0_ready, in1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_no_valid: ready0/1 got %b want 00", {in0_ready, in1_ready});
        end
    endtask

    task automatic test_single();
        do_op(1'b0, 8'h0F, 8'h11, 16'h00FF, 1'b0, 0, "single");
    endtask

    task automatic test_contention();
        apply_reset();
        in1_a = 8'h07; in1_b = 8'h09; in1_valid = 1'b1;
        do_op(1'b0, 8'h03, 8'h05, 16'h000F, 1'b0, 0, "contend_first");
        do_op(1'b1, 8'h07, 8'h09, 16'h003F, 1'b1, 0, "contend_second");
        in1_a = 8'h21; in1_b = 8'h04; in1_valid = 1'b1;
        do_op(1'b0, 8'h02, 8'h08, 16'h0010, 1'b0, 0, "contend_again");
        in1_valid = 1'b0;
    endtask

    task automatic test_max();
        do_op(1'b1, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 0, "max_operands");
    endtask

    task automatic test_backpressure();
        // in1 waits through the whole in0 operation, then is served.
        in1_a = 8'h02; in1_b = 8'h03; in1_valid = 1'b1;
        do_op(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b0, 5, "backpressure");
        do_op(1'b1, 8'h02, 8'h03, 16'h0006, 1'b1, 0, "waited_in1");
    endtask

    task automatic test_reset_mid_run();
        int seen;
        in0_a = 8'h0A; in0_b = 8'h0B; in0_valid = 1'b1;
        @(negedge clk);                 // T+1
        in0_valid = 1'b0;
        repeat (7) @(negedge clk);      // T+8
        rst = 1'b1;
        @(negedge clk);                 // T+9
        rst = 1'b0;
        #1;
        total++;
        if ({dp_a, dp_b, dp_sync0, dp_sync1, dp_sync2, res_valid, res_q, res_id, busy} !== '0) begin
            bad++;
            $display("FAIL midrun_reset_outputs: got a=%h b=%h s=%b rv=%b q=%h id=%b busy=%b want all 0",
                     dp_a, dp_b, {dp_sync0, dp_sync1, dp_sync2}, res_valid, res_q, res_id, busy);
        end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            #1;
            if (res_valid || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrun_no_result: cycles with rv/busy got %0d want 0", seen);
        end
        in1_a = 8'h05; in1_b = 8'h05; in1_valid = 1'b1;
        do_op(1'b0, 8'h0A, 8'h0B, 16'h006E, 1'b0, 0, "midrun_after");
        in1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int accepts, prev, s0, s1, s2, waited;
        accepts = 0; prev = -1; s0 = 0; s1 = 0; s2 = 0;
        in0_a = 8'h05; in0_b = 8'h06; in0_valid = 1'b1;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && accepts < 3; cyc++) begin
            s0 += int'(dp_sync0); s1 += int'(dp_sync1); s2 += int'(dp_sync2);
            if (res_valid) begin
                total++;
                if (res_q !== 16'h001E) begin
                    bad++;
                    $display("FAIL b2b_result cyc %0d: got %h want 001e", cyc, res_q);
                end
            end
            if (in0_valid && in0_ready) begin
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev !== RES_LAT + 3) begin
                        bad++;
                        $display("FAIL b2b_spacing: got %0d want %0d", cyc - prev, RES_LAT + 3);
                    end
                    total++;
                    if ({s0, s1, s2} !== {32'd1, 32'd1, 32'd1}) begin
                        bad++;
                        $display("FAIL b2b_strobes: s0/s1/s2 got %0d/%0d/%0d want 1/1/1", s0, s1, s2);
                    end
                end
                prev = cyc; s0 = 0; s1 = 0; s2 = 0;
                accepts++;
            end
            @(negedge clk);
            #1;
        end
        in0_valid = 1'b0;
        total++;
        if (accepts !== 3) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d want 3", accepts);
        end
        waited = 0;
        while (busy && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: busy got %b want 0 after %0d cycles", busy, waited);
        end
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_max();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
